bit_cpt_n: RTL and testbench
============================

// Module: bit_cpt_n
// PURPOSE
//   Parametrised synchronous up/down counter; generalises the fixed 3-bit counter.
//   Configurable width and modulo limit. Selects wrap or saturate at runtime-fixed parameter.
//   Adds synchronous parallel load, terminal-count flag and a one-cycle overflow/underflow pulse.
//   Serves as the generic event/sequence counter for timers and sequencers in the compteur library.
// PARAMETERS
//   WIDTH    3  counter width in bits, >= 1
//   MAX      7  modulo limit (highest count value); 1 <= MAX <= 2**WIDTH-1
//   SATURATE 0  0: wrap at bounds; 1: hold at bounds
// PORTS
//   clk       in   1      clock; all state updates on posedge
//   reset     in   1      asynchronous, active-low reset
//   activate  in   1      count enable; 1 = step this edge
//   up_down   in   1      direction; 1 = up, 0 = down
//   load      in   1      synchronous parallel load
//   load_val  in   WIDTH  value loaded when load=1
//   cpt       out  WIDTH  current count (registered)
//   tc        out  1      terminal count (combinational from cpt and up_down)
//   ovf       out  1      wrap/limit event pulse (registered)
// BEHAVIOUR
//   Reset:
//     - reset=0 forces cpt=0 and ovf=0 immediately, independent of clk.
//     - A mid-count reset discards state; counting resumes from 0 on the first posedge after reset=1.
//   Priority on posedge, reset released: load > activate > hold.
//   load=1:
//     - cpt <= min(load_val, MAX); out-of-range values clamp to MAX.
//     - ovf <= 0.
//     - activate and up_down are ignored this cycle.
//   activate=1, up_down=1 (up):
//     - cpt < MAX: cpt <= cpt+1, ovf <= 0.
//     - cpt == MAX: cpt <= 0 (SATURATE=0) or MAX (SATURATE=1); ovf <= 1.
//   activate=1, up_down=0 (down):
//     - cpt > 0: cpt <= cpt-1, ovf <= 0.
//     - cpt == 0: cpt <= MAX (SATURATE=0) or 0 (SATURATE=1); ovf <= 1.
//   activate=0, load=0: cpt holds, ovf <= 0.
//   ovf timing:
//     - Asserted exactly for the clock period following the boundary edge.
//     - In saturate mode it re-asserts on every held attempt at the bound.
//   tc:
//     - 1 when (up_down=1 and cpt==MAX) or (up_down=0 and cpt==0), else 0.
//     - Not gated by activate.
//   Latency: cpt and ovf change one clock after the qualifying inputs; tc tracks cpt with zero latency.
//   Arithmetic:
//     - Comparisons are unsigned, WIDTH bits.
//     - No value above MAX is ever reachable.
//   Direction changes take effect on the same edge with no dead cycle.
// TESTING
//   1. Reset/count-up:
//      - Stimulus: reset=0 then 1; activate=1, up_down=1; WIDTH=3, MAX=7.
//      - Response: cpt 0,1,..,7,0; ovf=1 for exactly one cycle after 7->0; tc=1 while cpt=7.
//   2. Modulo limit:
//      - Stimulus: MAX=5, counting up.
//      - Response: cpt 0..5,0; value 6 never appears.
//   3. Down wrap/saturate:
//      - Stimulus: from 0, up_down=0, activate=1.
//      - Response: SATURATE=0 gives cpt=MAX then MAX-1 with a single ovf pulse; SATURATE=1 holds cpt=0 and ovf stays 1 while activate=1.
//   4. Load priority:
//      - Stimulus: load=1, load_val=3, activate=1 at cpt=6.
//      - Response: cpt=3, ovf=0. With MAX=5 and load_val=7: cpt=5.
//   5. Asynchronous reset mid-count:
//      - Stimulus: reset=0 between clock edges at cpt=4.
//      - Response: cpt=0 and ovf=0 before the next posedge; hold/activate=0 keeps cpt stable.
//   6. Direction flip:
//      - Stimulus: at cpt=2, toggle up_down each edge with activate=1.
//      - Response: cpt 2,3,2,3; tc follows up_down combinationally at the bounds.

Source files
------------

// File: rtl/bit_cpt_n.sv
// Generic up/down event counter: WIDTH bits, modulo MAX, wrap or saturate, parallel load, tc flag, boundary pulse.
// Latency: cpt/ovf update one clock after qualifying inputs; tc is combinational from cpt and up_down.
// Backpressure: none; the counter accepts a load or step on every clock edge.
module bit_cpt_n #(
    parameter int WIDTH    = 3,
    parameter int MAX      = 7,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             activate,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cpt,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] LP_ZERO = '0;
    localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);
    localparam logic             LP_SAT  = (SATURATE != 0);

    logic [WIDTH-1:0] r_cpt;
    logic             r_ovf;
    logic [WIDTH-1:0] w_cpt_nxt;
    logic             w_ovf_nxt;
    logic             w_at_top;
    logic             w_at_bot;

    assign w_at_top = (r_cpt == LP_MAX);
    assign w_at_bot = (r_cpt == LP_ZERO);

    // Next count and boundary pulse: load beats activate beats hold; the bound value depends on wrap/saturate mode.
    always_comb begin
        w_cpt_nxt = r_cpt;
        w_ovf_nxt = 1'b0;
        if (load) begin
            w_cpt_nxt = (load_val > LP_MAX) ? LP_MAX : load_val;
        end else if (activate) begin
            if (up_down) begin
                if (w_at_top) begin
                    w_cpt_nxt = LP_SAT ? LP_MAX : LP_ZERO;
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_cpt_nxt = r_cpt + LP_ONE;
                end
            end else begin
                if (w_at_bot) begin
                    w_cpt_nxt = LP_SAT ? LP_ZERO : LP_MAX;
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_cpt_nxt = r_cpt - LP_ONE;
                end
            end
        end
    end

    // Count and pulse registers; reset clears both immediately, independent of the clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpt <= LP_ZERO;
            r_ovf <= 1'b0;
        end else begin
            r_cpt <= w_cpt_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    // Terminal count looks at the bound in the current direction, regardless of activate.
    always_comb begin
        tc = 1'b0;
        if (up_down) begin
            tc = w_at_top;
        end else begin
            tc = w_at_bot;
        end
    end

    assign cpt = r_cpt;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_bit_cpt_n.sv
// Directed bench for bit_cpt_n: three instances share stimulus (MAX=7 wrap, MAX=5 wrap, MAX=7 saturate).
// Outputs sampled 1 time unit after each rising edge; inputs changed at the same point.
// Expected values are written out by hand per vector.
module tb_bit_cpt_n;

    logic       clk;
    logic       reset;
    logic       activate;
    logic       up_down;
    logic       load;
    logic [2:0] load_val;

    logic [2:0] cpt_a, cpt_b, cpt_c;
    logic       tc_a, tc_b, tc_c;
    logic       ovf_a, ovf_b, ovf_c;

    int n_vec;
    int n_err;

    bit_cpt_n #(.WIDTH(3), .MAX(7), .SATURATE(0)) u_a (
        .clk(clk), .reset(reset), .activate(activate), .up_down(up_down),
        .load(load), .load_val(load_val), .cpt(cpt_a), .tc(tc_a), .ovf(ovf_a));

    bit_cpt_n #(.WIDTH(3), .MAX(5), .SATURATE(0)) u_b (
        .clk(clk), .reset(reset), .activate(activate), .up_down(up_down),
        .load(load), .load_val(load_val), .cpt(cpt_b), .tc(tc_b), .ovf(ovf_b));

    bit_cpt_n #(.WIDTH(3), .MAX(7), .SATURATE(1)) u_c (
        .clk(clk), .reset(reset), .activate(activate), .up_down(up_down),
        .load(load), .load_val(load_val), .cpt(cpt_c), .tc(tc_c), .ovf(ovf_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed count-up table for k = 1..7 edges after reset release.
    int exp_b_up [1:7] = '{1, 2, 3, 4, 5, 0, 1};
    int exp_bo_up[1:7] = '{0, 0, 0, 0, 0, 1, 0};

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b0;
        activate = 1'b0;
        up_down  = 1'b1;
        load     = 1'b0;
        load_val = 3'd0;

        // Reset state, held across an edge.
        #2;
        chk("rst_cpt_a", cpt_a, 0);
        chk("rst_ovf_a", ovf_a, 0);
        chk("rst_tc_a",  tc_a,  0);
        step();
        chk("rst_edge_cpt_c", cpt_c, 0);

        // Count up from 0 through the wrap.
        reset    = 1'b1;
        activate = 1'b1;
        up_down  = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("up%0d_cpt_a", k), cpt_a, k);
            chk($sformatf("up%0d_ovf_a", k), ovf_a, 0);
            chk($sformatf("up%0d_tc_a",  k), tc_a,  (k == 7) ? 1 : 0);
            chk($sformatf("up%0d_cpt_b", k), cpt_b, exp_b_up[k]);
            chk($sformatf("up%0d_ovf_b", k), ovf_b, exp_bo_up[k]);
            chk($sformatf("up%0d_cpt_c", k), cpt_c, k);
        end
        step();
        chk("wrap_cpt_a", cpt_a, 0);
        chk("wrap_ovf_a", ovf_a, 1);
        chk("wrap_tc_a",  tc_a,  0);
        chk("sat_cpt_c",  cpt_c, 7);
        chk("sat_ovf_c",  ovf_c, 1);
        chk("sat_tc_c",   tc_c,  1);
        chk("up9_cpt_b",  cpt_b, 2);
        step();
        chk("post_cpt_a",  cpt_a, 1);
        chk("post_ovf_a",  ovf_a, 0);
        chk("sat2_cpt_c",  cpt_c, 7);
        chk("sat2_ovf_c",  ovf_c, 1);
        chk("up10_cpt_b",  cpt_b, 3);

        // Down from 0: wrap to MAX vs hold at 0.
        load     = 1'b1;
        load_val = 3'd0;
        step();
        chk("ld0_cpt_a", cpt_a, 0);
        chk("ld0_ovf_c", ovf_c, 0);
        load    = 1'b0;
        up_down = 1'b0;
        #1;
        chk("dn_tc_a_comb", tc_a, 1);
        step();
        chk("dn1_cpt_a", cpt_a, 7);
        chk("dn1_ovf_a", ovf_a, 1);
        chk("dn1_cpt_b", cpt_b, 5);
        chk("dn1_ovf_b", ovf_b, 1);
        chk("dn1_cpt_c", cpt_c, 0);
        chk("dn1_ovf_c", ovf_c, 1);
        step();
        chk("dn2_cpt_a", cpt_a, 6);
        chk("dn2_ovf_a", ovf_a, 0);
        chk("dn2_cpt_b", cpt_b, 4);
        chk("dn2_cpt_c", cpt_c, 0);
        chk("dn2_ovf_c", ovf_c, 1);
        step();
        chk("dn3_cpt_a", cpt_a, 5);
        chk("dn3_ovf_c", ovf_c, 1);

        // Load priority over activate, and clamping to MAX.
        load     = 1'b1;
        load_val = 3'd6;
        step();
        chk("ld6_cpt_a", cpt_a, 6);
        chk("ld6_cpt_b", cpt_b, 5);
        up_down  = 1'b1;
        load_val = 3'd3;
        step();
        chk("ld3_cpt_a", cpt_a, 3);
        chk("ld3_ovf_a", ovf_a, 0);
        chk("ld3_cpt_b", cpt_b, 3);
        load_val = 3'd7;
        step();
        chk("ld7_cpt_a", cpt_a, 7);
        chk("ld7_cpt_b", cpt_b, 5);
        chk("ld7_tc_b",  tc_b,  1);

        // Mid-cycle asynchronous reset with ovf set.
        load = 1'b0;
        step();
        chk("pre_rst_ovf_a", ovf_a, 1);
        chk("pre_rst_cpt_c", cpt_c, 7);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_cpt_a", cpt_a, 0);
        chk("arst_ovf_a", ovf_a, 0);
        chk("arst_cpt_c", cpt_c, 0);
        chk("arst_ovf_c", ovf_c, 0);
        activate = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("hold_cpt_a", cpt_a, 0);
        chk("hold_ovf_a", ovf_a, 0);
        step();
        chk("hold2_cpt_a", cpt_a, 0);

        // Direction flip from 2.
        load     = 1'b1;
        load_val = 3'd2;
        step();
        chk("ld2_cpt_a", cpt_a, 2);
        load     = 1'b0;
        activate = 1'b1;
        up_down  = 1'b1;
        step();
        chk("flip1_cpt_a", cpt_a, 3);
        up_down = 1'b0;
        step();
        chk("flip2_cpt_a", cpt_a, 2);
        up_down = 1'b1;
        step();
        chk("flip3_cpt_a", cpt_a, 3);
        chk("flip3_ovf_a", ovf_a, 0);

        // tc follows up_down combinationally at both bounds.
        activate = 1'b0;
        load     = 1'b1;
        load_val = 3'd7;
        step();
        load = 1'b0;
        chk("tc_top_up", tc_a, 1);
        up_down = 1'b0;
        #1;
        chk("tc_top_dn", tc_a, 0);
        load     = 1'b1;
        load_val = 3'd0;
        step();
        load = 1'b0;
        chk("tc_bot_dn", tc_a, 1);
        up_down = 1'b1;
        #1;
        chk("tc_bot_up", tc_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
